// File: rtl/temperature_abnormality_monitor.sv
// Two-stage abs/popcount pipeline with valid/ready backpressure and a sticky persistence alarm.
// Optional peak-hold output peakAbs is enabled by defining TAD_PEAK_HOLD_EN.
module temperature_abnormality_monitor #(
   parameter int DATA_W  = 8,
   parameter int CNT_W   = 4,
   parameter int THRESH  = 4,
   parameter int PERSIST = 3
) (
   input  logic              clk,
   input  logic              rstN,
   input  logic              sampleValid,
   input  logic [DATA_W-1:0] sample,
   output logic              sampleReady,
   output logic              indexValid,
   input  logic              indexReady,
   output logic [DATA_W-1:0] absValue,
   output logic [CNT_W-1:0]  glycemicIndex,
   output logic              alarm,
   input  logic              alarmClear
`ifdef TAD_PEAK_HOLD_EN
   ,
   output logic [DATA_W-1:0] peakAbs
`endif
);

   typedef enum logic [1:0] {IDLE, COUNT, ALARM} state_t;

   state_t            state;
   logic [7:0]        run;
   logic              readyEn;
   logic              s1Valid;
   logic [DATA_W-1:0] s1Abs;
   logic [DATA_W-1:0] sampleAbs;
   logic              stall2;
   logic              accept;
   logic              deliver;
   logic              qualify;

   function automatic logic [CNT_W-1:0] popCount(input logic [DATA_W-1:0] v);
      logic [CNT_W-1:0] c;
      c = '0;
      for (int i = 0; i < DATA_W; i++) c = c + CNT_W'(v[i]);
      return c;
   endfunction

   // Two's-complement negate; the most-negative code maps onto itself as unsigned 2^(DATA_W-1).
   assign sampleAbs   = sample[DATA_W-1] ? (~sample + 1'b1) : sample;
   assign stall2      = indexValid & ~indexReady;
   // readyEn keeps sampleReady low while reset is held and for the first edge after release.
   assign sampleReady = readyEn & (~s1Valid | ~stall2);
   assign accept      = sampleValid & sampleReady;
   assign deliver     = indexValid & indexReady;
   assign qualify     = 32'(glycemicIndex) >= THRESH;

   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) begin
         readyEn       <= 1'b0;
         s1Valid       <= 1'b0;
         s1Abs         <= '0;
         indexValid    <= 1'b0;
         absValue      <= '0;
         glycemicIndex <= '0;
      end else begin
         readyEn <= 1'b1;
         if (accept) begin
            s1Valid <= 1'b1;
            s1Abs   <= sampleAbs;
         end else if (!stall2) begin
            s1Valid <= 1'b0;
         end
         if (!stall2) begin
            indexValid    <= s1Valid;
            absValue      <= s1Abs;
            glycemicIndex <= popCount(s1Abs);
         end
      end
   end

   // Persistence FSM: only delivers advance it; a clear always wins.
   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) begin
         state <= IDLE;
         run   <= '0;
         alarm <= 1'b0;
      end else if (alarmClear) begin
         state <= IDLE;
         run   <= '0;
         alarm <= 1'b0;
      end else if (deliver) begin
         case (state)
            IDLE: begin
               if (qualify) begin
                  run <= 8'd1;
                  if (PERSIST == 1) begin
                     state <= ALARM;
                     alarm <= 1'b1;
                  end else begin
                     state <= COUNT;
                  end
               end
            end
            COUNT: begin
               if (qualify) begin
                  run <= run + 8'd1;
                  if (run == 8'(PERSIST - 1)) begin
                     state <= ALARM;
                     alarm <= 1'b1;
                  end
               end else begin
                  state <= IDLE;
                  run   <= '0;
               end
            end
            ALARM: ;
            default: begin
               state <= IDLE;
               run   <= '0;
               alarm <= 1'b0;
            end
         endcase
      end
   end

`ifdef TAD_PEAK_HOLD_EN
   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN)                              peakAbs <= '0;
      else if (alarmClear)                    peakAbs <= '0;
      else if (deliver && absValue > peakAbs) peakAbs <= absValue;
   end
`endif

endmodule

// File: tb/tb_temperature_abnormality_monitor.sv
// Randomized + directed bench for temperature_abnormality_monitor against a transaction-level model.
module tb_temperature_abnormality_monitor;
   localparam int DW = 8, CW = 4, TH = 4, PS = 3;

   logic          clk = 1'b0, rstN = 1'b0;
   logic          sampleValid = 1'b0, indexReady = 1'b1, alarmClear = 1'b0;
   logic [DW-1:0] sample = '0;
   logic          sampleReady, indexValid, alarm;
   logic [DW-1:0] absValue;
   logic [CW-1:0] glycemicIndex;
`ifdef TAD_PEAK_HOLD_EN
   logic [DW-1:0] peakAbs;
`endif

   temperature_abnormality_monitor #(.DATA_W(DW), .CNT_W(CW), .THRESH(TH), .PERSIST(PS)) dut (
      .clk(clk), .rstN(rstN), .sampleValid(sampleValid), .sample(sample),
      .sampleReady(sampleReady), .indexValid(indexValid), .indexReady(indexReady),
      .absValue(absValue), .glycemicIndex(glycemicIndex), .alarm(alarm), .alarmClear(alarmClear)
`ifdef TAD_PEAK_HOLD_EN
      , .peakAbs(peakAbs)
`endif
   );

   always #5 clk = ~clk;

   int errors = 0, checks = 0;
   logic [DW-1:0] q[$];           // samples accepted but not yet delivered
   int  runM = 0;
   bit  alarmM = 0;
   int  peakM = 0;
   int  accCnt = 0;
   bit  holdChk = 0;
   logic [DW-1:0] holdAbs;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic int absOf(input logic [DW-1:0] s);
      int v = int'($signed(s));
      return (v < 0) ? -v : v;
   endfunction

   // One clock: inputs already driven at negedge; ends at the following negedge.
   task automatic step();
      bit acc, dlv;
      int a;
      #1;
      acc = sampleValid && sampleReady;
      dlv = indexValid && indexReady;
      if (holdChk && indexValid) chk("stallStable", absValue, holdAbs);
      holdChk = indexValid && !indexReady;
      holdAbs = absValue;
      if (dlv) begin
         if (q.size() == 0) chk("spuriousDeliver", 1, 0);
         else begin
            a = absOf(q.pop_front());
            chk("absValue", absValue, a);
            chk("glycemicIndex", glycemicIndex, $countones(a));
         end
      end
      if (acc) begin
         q.push_back(sample);
         accCnt++;
      end
      if (alarmClear) begin
         runM = 0; alarmM = 0; peakM = 0;
      end else if (dlv) begin
         if (!alarmM) begin
            if ($countones(absValue) >= TH) begin
               runM++;
               if (runM >= PS) alarmM = 1;
            end else runM = 0;
         end
         if (int'(absValue) > peakM) peakM = int'(absValue);
      end
      @(posedge clk);
      @(negedge clk);
      chk("alarm", alarm, alarmM);
`ifdef TAD_PEAK_HOLD_EN
      chk("peakAbs", peakAbs, peakM);
`endif
   endtask

   task automatic send(input logic [DW-1:0] s);
      sampleValid = 1'b1; sample = s;
      step();
      sampleValid = 1'b0;
   endtask

   task automatic drain();
      sampleValid = 1'b0; indexReady = 1'b1;
      for (int i = 0; i < 4; i++) step();
      chk("drained", q.size(), 0);
   endtask

   task automatic clearAlarm();
      alarmClear = 1'b1; step(); alarmClear = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      logic [DW-1:0] vec[4];
      #1;
      chk("rstReady", sampleReady, 0);
      chk("rstIndexValid", indexValid, 0);
      chk("rstAbs", absValue, 0);
      chk("rstIndex", glycemicIndex, 0);
      chk("rstAlarm", alarm, 0);
      @(negedge clk); @(negedge clk);
      rstN = 1'b1;
      step();
      chk("readyAfterRst", sampleReady, 1);

      // Back-to-back vectors with two-edge latency
      vec = '{8'hB3, 8'h83, 8'h73, 8'h09};
      send(vec[0]);
      chk("lat1Valid", indexValid, 0);
      sampleValid = 1'b1; sample = vec[1]; step();
      chk("lat2Valid", indexValid, 1);
      chk("lat2Abs", absValue, 8'h4D);
      sample = vec[2]; step();
      chk("vec2Abs", absValue, 8'h7D);
      chk("vec2Idx", glycemicIndex, 6);
      sample = vec[3]; step();
      chk("vec3Abs", absValue, 8'h73);
      chk("alarmNotYet", alarm, 0);
      sampleValid = 1'b0; step();
      chk("alarmThird", alarm, 1);
      drain();
      chk("alarmSticky", alarm, 1);
      clearAlarm();
      chk("alarmCleared", alarm, 0);

      // Boundary values
      send(8'h80); send(8'h00); send(8'hFF); drain();

      // Run broken by a low index
      send(8'hB3); send(8'h83); send(8'h09); send(8'h73); drain();
      chk("noAlarmBroken", alarm, 0);
      clearAlarm();

      // Backpressure: stage 2 stalled, exactly two samples enter
      indexReady = 1'b0; accCnt = 0; sampleValid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         sample = 8'($urandom);
         step();
      end
      chk("bpAccepted", accCnt, 2);
      #1 chk("bpReadyLow", sampleReady, 0);
      drain();
      clearAlarm();

      // Clear coincident with the third qualifying deliver
      sampleValid = 1'b1;
      sample = 8'hB3; step();
      sample = 8'h83; step();
      sample = 8'h73; step();
      sampleValid = 1'b0; step();
      alarmClear = 1'b1; step(); alarmClear = 1'b0;
      chk("clearWins", alarm, 0);
      drain();

`ifdef TAD_PEAK_HOLD_EN
      send(8'hB3); send(8'h83); send(8'h73); send(8'h09); drain();
      chk("peak7D", peakAbs, 8'h7D);
      clearAlarm();
`endif

      // Randomized traffic
      for (int i = 0; i < 500; i++) begin
         sampleValid = ($urandom_range(0, 3) != 0);
         sample      = 8'($urandom);
         indexReady  = ($urandom_range(0, 9) < 7);
         alarmClear  = ($urandom_range(0, 29) == 0);
         step();
      end
      alarmClear = 1'b0;
      drain();

      // Async reset with both stages full
      indexReady = 1'b0; sampleValid = 1'b1;
      for (int i = 0; i < 3; i++) begin sample = 8'hB3; step(); end
      #2 rstN = 1'b0;
      #1;
      chk("midRstValid", indexValid, 0);
      chk("midRstReady", sampleReady, 0);
      chk("midRstAbs", absValue, 0);
      chk("midRstIdx", glycemicIndex, 0);
      chk("midRstAlarm", alarm, 0);
      q.delete(); runM = 0; alarmM = 0; peakM = 0; holdChk = 0;
      sampleValid = 1'b0; indexReady = 1'b1;
      @(negedge clk); rstN = 1'b1;
      for (int i = 0; i < 4; i++) begin
         step();
         chk("noStaleIndex", indexValid, 0);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
